id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the register file. Captures decoded operands, register indices, immediate and control bundle each cycle and presents them to EX.
- Contains load-use hazard detection. Generates the upstream stall (PC and IF/ID hold) and inserts a bubble into EX.
- Honours an EX-side hold and a branch/jump flush.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- XLEN, 32, operand/PC/immediate width (equals `REG_DATA_WIDTH).
- RA_W, 5, register index width (equals `RS_WIDTH).
- CTRL_W, 10, control bundle width, packed {regwrite, memread, memwrite, memtoreg, alusrc, branch, jump, aluop[2:0]}.
- CNT_W, 16, event counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of ID instruction.
- id_rs1, id_rs2  in  RA_W  source indices.
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2.
- id_rd  in  RA_W  destination index.
- id_rdata1, id_rdata2  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_ctrl  in  CTRL_W  decoded control.
- ex_hold  in  1  EX cannot accept a new instruction this cycle.
- flush  in  1  taken branch/jump resolved in EX; squash ID.
- ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_ctrl  out  registered copies.
- stall_up  out  1  hold PC and IF/ID this cycle.
- stall_cnt, flush_cnt  out  CNT_W  event counters.

Behaviour:
- Reset (rst=0 at a clock edge): every ex_* output is 0 (ex_ctrl=0, so bubble semantics). Both counters are 0.
- Reset mid-stream discards the captured instruction. The first valid capture happens on the first edge with rst=1.
- load_use is combinational: ex_valid & ex_ctrl.memread & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)) & id_valid.
- stall_up = (load_use | ex_hold) & ~flush. It has zero latency and is a pure function of current inputs and registers.
- Per-edge update priority (rst=1):
  1. flush: bubble (ex_valid=0, ex_ctrl=0; data fields don't-care, implemented as 0). flush_cnt += 1.
  2. else ex_hold: all ex_* hold their values. If load_use is also asserted, stall_cnt += 1.
  3. else load_use: bubble inserted. stall_cnt += 1. ID instruction stays upstream, re-evaluated next cycle.
  4. else normal capture: ex_* <= id_*. ex_valid <= id_valid. ex_ctrl <= id_valid ? id_ctrl : 0.
- Bubble guarantee: ex_ctrl regwrite/memwrite/branch/jump are 0 whenever ex_valid=0.
- Latency: one cycle from ID inputs to ex_*.
- A load-use pair resolves after exactly one bubble. The load moves to MEM, ex_rd changes, load_use drops.
- Hazard on x0 never stalls (ex_rd==0 check).
- Simultaneous flush and load_use: flush wins, stall_up=0, only flush_cnt increments.
- Simultaneous flush and ex_hold: flush wins; EX owner guarantees the squash is safe.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- WB→ID forwarding is not done here; the register file already returns the same-cycle write data.

Test Plan:
- Reset: rst=0 for 2 cycles with id_valid=1, id_ctrl=10'h3FF → all ex_*=0, stall_up=0, counters 0. Release rst, next edge → ex_ctrl=10'h3FF, ex_valid=1.
- Normal flow: id_pc=0x100, rdata1=0x11, rdata2=0x22, imm=0xFFFFFFF0, rd=5 → one cycle later ex_* equal these. stall_up=0 throughout.
- Load-use: EX holds lw x7 (memread=1, rd=7), ID add reads rs2=7 with use_rs2=1 → stall_up=1 that cycle. Next edge ex_valid=0, ex_ctrl=0, stall_cnt=1. Following edge the add is captured and stall_up=0.
- No false hazard:
  - lw x0 in EX with ID rs1=0 → no stall.
  - lw x7 in EX with ID rs1=7 but use_rs1=0 → no stall.
- Flush priority: load_use condition true and flush=1 together → stall_up=0, ex_valid=0 next edge, flush_cnt=1, stall_cnt=0.
- Hold and saturation:
  - ex_hold=1 for 3 cycles while ID inputs change → ex_* frozen.
  - Preload-equivalent: 65540 load-use cycles → stall_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage
//
// ID/EX pipeline register sitting directly after the register file. Each
// cycle it captures the decoded operands, register indices, immediate and
// control bundle and presents them to EX. It detects load-use hazards and
// asks upstream to stall while it inserts a bubble. It also honours an
// EX-side hold and a branch/jump flush, and keeps saturating debug
// counters for stall and flush events.
//
// Ports
//   clk_i            clock, all state changes on the rising edge
//   rst_i            synchronous active-low reset (0 = reset)
//   id_valid_i       ID stage holds a real instruction
//   id_pc_i          PC of the ID instruction
//   id_rs1_i/rs2_i   source register indices
//   id_use_rs1_i/2   instruction really reads rs1/rs2
//   id_rd_i          destination register index
//   id_rdata1_i/2_i  register-file read data
//   id_imm_i         sign-extended immediate
//   id_ctrl_i        control bundle {regwrite, memread, memwrite, memtoreg,
//                    alusrc, branch, jump, aluop[2:0]}
//   ex_hold_i        EX cannot accept a new instruction this cycle
//   flush_i          taken branch/jump resolved in EX, squash ID
//   ex_*_o           registered copies presented to EX
//   stall_up_o       hold PC and IF/ID this cycle
//   stall_cnt_o      saturating count of load-use stall cycles
//   flush_cnt_o      saturating count of flushes
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [RA_W-1:0]   id_rs1_i,
  input  logic [RA_W-1:0]   id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [RA_W-1:0]   id_rd_i,
  input  logic [XLEN-1:0]   id_rdata1_i,
  input  logic [XLEN-1:0]   id_rdata2_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              ex_hold_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [RA_W-1:0]   ex_rs1_o,
  output logic [RA_W-1:0]   ex_rs2_o,
  output logic [RA_W-1:0]   ex_rd_o,
  output logic [XLEN-1:0]   ex_rdata1_o,
  output logic [XLEN-1:0]   ex_rdata2_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              stall_up_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  // memread is the second-highest bit of the control bundle
  localparam int CtrlMemRead = CTRL_W - 2;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              exValid_q,  exValid_d;
  logic [XLEN-1:0]   exPc_q,     exPc_d;
  logic [RA_W-1:0]   exRs1_q,    exRs1_d;
  logic [RA_W-1:0]   exRs2_q,    exRs2_d;
  logic [RA_W-1:0]   exRd_q,     exRd_d;
  logic [XLEN-1:0]   exRdata1_q, exRdata1_d;
  logic [XLEN-1:0]   exRdata2_q, exRdata2_d;
  logic [XLEN-1:0]   exImm_q,    exImm_d;
  logic [CTRL_W-1:0] exCtrl_q,   exCtrl_d;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;

  logic loadUse;
  logic rs1Match;
  logic rs2Match;

  // A load whose destination is x0 never produces a hazard.
  assign rs1Match = id_use_rs1_i && (id_rs1_i == exRd_q);
  assign rs2Match = id_use_rs2_i && (id_rs2_i == exRd_q);
  assign loadUse  = exValid_q && exCtrl_q[CtrlMemRead] && (exRd_q != '0) &&
                    (rs1Match || rs2Match) && id_valid_i;

  // A flush squashes the ID instruction, so there is nothing left to hold.
  assign stall_up_o = (loadUse || ex_hold_i) && !flush_i;

  // Next-state selection in priority order: flush, EX hold, load-use
  // bubble, normal capture.
  always_comb begin
    exValid_d  = exValid_q;
    exPc_d     = exPc_q;
    exRs1_d    = exRs1_q;
    exRs2_d    = exRs2_q;
    exRd_d     = exRd_q;
    exRdata1_d = exRdata1_q;
    exRdata2_d = exRdata2_q;
    exImm_d    = exImm_q;
    exCtrl_d   = exCtrl_q;
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;

    if (flush_i) begin
      exValid_d  = 1'b0;
      exPc_d     = '0;
      exRs1_d    = '0;
      exRs2_d    = '0;
      exRd_d     = '0;
      exRdata1_d = '0;
      exRdata2_d = '0;
      exImm_d    = '0;
      exCtrl_d   = '0;
      if (flushCnt_q != CntMax) flushCnt_d = flushCnt_q + CntOne;
    end else if (ex_hold_i) begin
      // EX registers stay frozen, but a pending hazard still costs a cycle.
      if (loadUse && (stallCnt_q != CntMax)) stallCnt_d = stallCnt_q + CntOne;
    end else if (loadUse) begin
      exValid_d  = 1'b0;
      exPc_d     = '0;
      exRs1_d    = '0;
      exRs2_d    = '0;
      exRd_d     = '0;
      exRdata1_d = '0;
      exRdata2_d = '0;
      exImm_d    = '0;
      exCtrl_d   = '0;
      if (stallCnt_q != CntMax) stallCnt_d = stallCnt_q + CntOne;
    end else begin
      exValid_d  = id_valid_i;
      exPc_d     = id_pc_i;
      exRs1_d    = id_rs1_i;
      exRs2_d    = id_rs2_i;
      exRd_d     = id_rd_i;
      exRdata1_d = id_rdata1_i;
      exRdata2_d = id_rdata2_i;
      exImm_d    = id_imm_i;
      // Invalid slots carry no control so EX sees a clean bubble.
      exCtrl_d   = id_valid_i ? id_ctrl_i : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      exValid_q  <= 1'b0;
      exPc_q     <= '0;
      exRs1_q    <= '0;
      exRs2_q    <= '0;
      exRd_q     <= '0;
      exRdata1_q <= '0;
      exRdata2_q <= '0;
      exImm_q    <= '0;
      exCtrl_q   <= '0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      exValid_q  <= exValid_d;
      exPc_q     <= exPc_d;
      exRs1_q    <= exRs1_d;
      exRs2_q    <= exRs2_d;
      exRd_q     <= exRd_d;
      exRdata1_q <= exRdata1_d;
      exRdata2_q <= exRdata2_d;
      exImm_q    <= exImm_d;
      exCtrl_q   <= exCtrl_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign ex_valid_o  = exValid_q;
  assign ex_pc_o     = exPc_q;
  assign ex_rs1_o    = exRs1_q;
  assign ex_rs2_o    = exRs2_q;
  assign ex_rd_o     = exRd_q;
  assign ex_rdata1_o = exRdata1_q;
  assign ex_rdata2_o = exRdata2_q;
  assign ex_imm_o    = exImm_q;
  assign ex_ctrl_o   = exCtrl_q;
  assign stall_cnt_o = stallCnt_q;
  assign flush_cnt_o = flushCnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. A behavioural model of the EX-side
// instruction slot and the debug counters is advanced on every rising edge
// and compared against the DUT on every falling edge. Directed sequences
// cover reset, normal flow, load-use, false-hazard cases, flush priority,
// EX hold and counter saturation, with literal expectations at key points.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        idValid;
  logic [31:0] idPc;
  logic [4:0]  idRs1;
  logic [4:0]  idRs2;
  logic        idUseRs1;
  logic        idUseRs2;
  logic [4:0]  idRd;
  logic [31:0] idRdata1;
  logic [31:0] idRdata2;
  logic [31:0] idImm;
  logic [9:0]  idCtrl;
  logic        exHold;
  logic        flush;

  logic        exValid;
  logic [31:0] exPc;
  logic [4:0]  exRs1;
  logic [4:0]  exRs2;
  logic [4:0]  exRd;
  logic [31:0] exRdata1;
  logic [31:0] exRdata2;
  logic [31:0] exImm;
  logic [9:0]  exCtrl;
  logic        stallUp;
  logic [15:0] stallCnt;
  logic [15:0] flushCnt;

  int checks = 0;
  int errors = 0;

  // Control encodings used in the directed vectors
  localparam logic [9:0] CtrlLoad = 10'h340;
  localparam logic [9:0] CtrlAlu  = 10'h220;
  localparam logic [9:0] CtrlAdd  = 10'h200;

  id_ex_stage dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .id_valid_i   (idValid),
    .id_pc_i      (idPc),
    .id_rs1_i     (idRs1),
    .id_rs2_i     (idRs2),
    .id_use_rs1_i (idUseRs1),
    .id_use_rs2_i (idUseRs2),
    .id_rd_i      (idRd),
    .id_rdata1_i  (idRdata1),
    .id_rdata2_i  (idRdata2),
    .id_imm_i     (idImm),
    .id_ctrl_i    (idCtrl),
    .ex_hold_i    (exHold),
    .flush_i      (flush),
    .ex_valid_o   (exValid),
    .ex_pc_o      (exPc),
    .ex_rs1_o     (exRs1),
    .ex_rs2_o     (exRs2),
    .ex_rd_o      (exRd),
    .ex_rdata1_o  (exRdata1),
    .ex_rdata2_o  (exRdata2),
    .ex_imm_o     (exImm),
    .ex_ctrl_o    (exCtrl),
    .stall_up_o   (stallUp),
    .stall_cnt_o  (stallCnt),
    .flush_cnt_o  (flushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the instruction sitting in EX plus the two debug counters
  typedef struct {
    bit        valid;
    bit [31:0] pc;
    bit [4:0]  rs1;
    bit [4:0]  rs2;
    bit [4:0]  rd;
    bit [31:0] rdata1;
    bit [31:0] rdata2;
    bit [31:0] imm;
    bit [9:0]  ctrl;
    int        stallEvents;
    int        flushEvents;
  } exModel_t;

  exModel_t model;
  bit modelReady = 0;

  function automatic void clearSlot();
    model.valid  = 0;
    model.pc     = 0;
    model.rs1    = 0;
    model.rs2    = 0;
    model.rd     = 0;
    model.rdata1 = 0;
    model.rdata2 = 0;
    model.imm    = 0;
    model.ctrl   = 0;
  endfunction

  // The ID instruction needs a value that the load in EX has not yet fetched
  function automatic bit modelHazard();
    bit loadInEx;
    bit needsIt;
    loadInEx = model.valid && (model.ctrl[8] == 1'b1) && (model.rd != 0);
    needsIt  = (idUseRs1 && idRs1 == model.rd) || (idUseRs2 && idRs2 == model.rd);
    return loadInEx && needsIt && (idValid == 1'b1);
  endfunction

  function automatic bit modelStallUp();
    if (flush) return 0;
    return modelHazard() || (exHold == 1'b1);
  endfunction

  // Advance the model by one clock edge
  always @(posedge clk) begin
    bit hz;
    hz = modelHazard();
    if (!rst) begin
      clearSlot();
      model.stallEvents = 0;
      model.flushEvents = 0;
    end else if (flush) begin
      clearSlot();
      model.flushEvents = model.flushEvents + 1;
    end else if (exHold) begin
      if (hz) model.stallEvents = model.stallEvents + 1;
    end else if (hz) begin
      clearSlot();
      model.stallEvents = model.stallEvents + 1;
    end else begin
      model.valid  = idValid;
      model.pc     = idPc;
      model.rs1    = idRs1;
      model.rs2    = idRs2;
      model.rd     = idRd;
      model.rdata1 = idRdata1;
      model.rdata2 = idRdata2;
      model.imm    = idImm;
      model.ctrl   = idValid ? idCtrl : 10'h0;
    end
    modelReady = 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] saturate(input int count);
    return (count > 65535) ? 32'd65535 : count;
  endfunction

  // Compare every DUT output against the model on every falling edge
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("cmp_valid",  {31'b0, exValid}, {31'b0, model.valid});
      checkOutput("cmp_pc",     exPc,             model.pc);
      checkOutput("cmp_rs1",    {27'b0, exRs1},   {27'b0, model.rs1});
      checkOutput("cmp_rs2",    {27'b0, exRs2},   {27'b0, model.rs2});
      checkOutput("cmp_rd",     {27'b0, exRd},    {27'b0, model.rd});
      checkOutput("cmp_rdata1", exRdata1,         model.rdata1);
      checkOutput("cmp_rdata2", exRdata2,         model.rdata2);
      checkOutput("cmp_imm",    exImm,            model.imm);
      checkOutput("cmp_ctrl",   {22'b0, exCtrl},  {22'b0, model.ctrl});
      checkOutput("cmp_stall",  {31'b0, stallUp}, {31'b0, modelStallUp()});
      checkOutput("cmp_scnt",   {16'b0, stallCnt}, saturate(model.stallEvents));
      checkOutput("cmp_fcnt",   {16'b0, flushCnt}, saturate(model.flushEvents));
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] imm,
                               input logic [9:0] ctrl);
    idValid  = v;
    idPc     = pc;
    idRs1    = rs1;
    idUseRs1 = u1;
    idRs2    = rs2;
    idUseRs2 = u2;
    idRd     = rd;
    idRdata1 = d1;
    idRdata2 = d2;
    idImm    = imm;
    idCtrl   = ctrl;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst    = 1'b0;
    exHold = 1'b0;
    flush  = 1'b0;
    applyStimulus(1, 32'h40, 5'd1, 1, 5'd2, 1, 5'd0, 32'h1, 32'h2, 32'h3, 10'h3FF);

    // Reset held for two edges with a live instruction on the inputs
    stepClock();
    stepClock();
    checkOutput("rst_valid", {31'b0, exValid}, 32'd0);
    checkOutput("rst_ctrl",  {22'b0, exCtrl},  32'd0);
    checkOutput("rst_pc",    exPc,             32'd0);
    checkOutput("rst_stall", {31'b0, stallUp}, 32'd0);
    checkOutput("rst_scnt",  {16'b0, stallCnt}, 32'd0);
    checkOutput("rst_fcnt",  {16'b0, flushCnt}, 32'd0);

    // First edge out of reset captures the instruction
    rst = 1'b1;
    stepClock();
    checkOutput("rel_ctrl",  {22'b0, exCtrl},  32'h3FF);
    checkOutput("rel_valid", {31'b0, exValid}, 32'd1);

    // Normal flow
    applyStimulus(1, 32'h100, 5'd1, 1, 5'd2, 1, 5'd5, 32'h11, 32'h22, 32'hFFFF_FFF0, CtrlAlu);
    #1 checkOutput("nf_stall", {31'b0, stallUp}, 32'd0);
    stepClock();
    checkOutput("nf_pc",     exPc,           32'h100);
    checkOutput("nf_rdata1", exRdata1,       32'h11);
    checkOutput("nf_rdata2", exRdata2,       32'h22);
    checkOutput("nf_imm",    exImm,          32'hFFFF_FFF0);
    checkOutput("nf_rd",     {27'b0, exRd},  32'd5);
    checkOutput("nf_ctrl",   {22'b0, exCtrl}, {22'b0, CtrlAlu});

    // Load-use: lw x7 followed by an add reading x7 through rs2
    applyStimulus(1, 32'h104, 5'd2, 1, 5'd0, 0, 5'd7, 32'h0, 32'h0, 32'h8, CtrlLoad);
    stepClock();
    applyStimulus(1, 32'h108, 5'd3, 1, 5'd7, 1, 5'd8, 32'h33, 32'h0, 32'h0, CtrlAdd);
    #1 checkOutput("lu_stall", {31'b0, stallUp}, 32'd1);
    stepClock();
    checkOutput("lu_valid",  {31'b0, exValid},  32'd0);
    checkOutput("lu_ctrl",   {22'b0, exCtrl},   32'd0);
    checkOutput("lu_scnt",   {16'b0, stallCnt}, 32'd1);
    checkOutput("lu_nostall", {31'b0, stallUp}, 32'd0);
    stepClock();
    checkOutput("lu_rd",    {27'b0, exRd},    32'd8);
    checkOutput("lu_valid2", {31'b0, exValid}, 32'd1);

    // Load into x0 never stalls a reader of x0
    applyStimulus(1, 32'h10C, 5'd1, 1, 5'd0, 0, 5'd0, 32'h0, 32'h0, 32'h0, CtrlLoad);
    stepClock();
    applyStimulus(1, 32'h110, 5'd0, 1, 5'd9, 1, 5'd10, 32'h0, 32'h5, 32'h0, CtrlAdd);
    #1 checkOutput("x0_stall", {31'b0, stallUp}, 32'd0);
    stepClock();
    checkOutput("x0_rd", {27'b0, exRd}, 32'd10);

    // Index match on an unused source is not a hazard
    applyStimulus(1, 32'h114, 5'd0, 0, 5'd0, 0, 5'd7, 32'h0, 32'h0, 32'h0, CtrlLoad);
    stepClock();
    applyStimulus(1, 32'h118, 5'd7, 0, 5'd3, 1, 5'd11, 32'h0, 32'h0, 32'h0, CtrlAdd);
    #1 checkOutput("nu_stall", {31'b0, stallUp}, 32'd0);
    stepClock();
    checkOutput("nu_rd",   {27'b0, exRd},     32'd11);
    checkOutput("nu_scnt", {16'b0, stallCnt}, 32'd1);

    // Flush wins over a simultaneous load-use
    applyStimulus(1, 32'h11C, 5'd0, 0, 5'd0, 0, 5'd7, 32'h0, 32'h0, 32'h0, CtrlLoad);
    stepClock();
    applyStimulus(1, 32'h120, 5'd7, 1, 5'd0, 0, 5'd12, 32'h0, 32'h0, 32'h0, CtrlAdd);
    flush = 1'b1;
    #1 checkOutput("fl_stall", {31'b0, stallUp}, 32'd0);
    stepClock();
    flush = 1'b0;
    checkOutput("fl_valid", {31'b0, exValid},  32'd0);
    checkOutput("fl_fcnt",  {16'b0, flushCnt}, 32'd1);
    checkOutput("fl_scnt",  {16'b0, stallCnt}, 32'd1);

    // EX hold freezes the slot while ID keeps changing
    applyStimulus(1, 32'h200, 5'd1, 1, 5'd2, 1, 5'd12, 32'hA, 32'hB, 32'hC, CtrlAdd);
    stepClock();
    exHold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h300 + 32'(i * 4), 5'd3, 1, 5'd4, 1, 5'd13, 32'(i), 32'(i), 32'(i), CtrlAlu);
      #1 checkOutput("hd_stall", {31'b0, stallUp}, 32'd1);
      stepClock();
      checkOutput("hd_pc", exPc,          32'h200);
      checkOutput("hd_rd", {27'b0, exRd}, 32'd12);
    end
    exHold = 1'b0;

    // Saturation: held load-use accrues a stall every cycle
    applyStimulus(1, 32'h400, 5'd0, 0, 5'd0, 0, 5'd7, 32'h0, 32'h0, 32'h0, CtrlLoad);
    stepClock();
    exHold = 1'b1;
    applyStimulus(1, 32'h404, 5'd7, 1, 5'd0, 0, 5'd14, 32'h0, 32'h0, 32'h0, CtrlAdd);
    for (int i = 0; i < 65540; i++) stepClock();
    checkOutput("sat_scnt", {16'b0, stallCnt}, 32'h0000_FFFF);
    checkOutput("sat_rd",   {27'b0, exRd},     32'd7);
    exHold = 1'b0;
    stepClock();
    checkOutput("sat_bubble", {31'b0, exValid},  32'd0);
    checkOutput("sat_hold",   {16'b0, stallCnt}, 32'h0000_FFFF);

    // Reset mid-stream discards the slot and clears the counters
    applyStimulus(1, 32'h500, 5'd1, 1, 5'd2, 1, 5'd15, 32'h1, 32'h2, 32'h3, CtrlAdd);
    rst = 1'b0;
    stepClock();
    checkOutput("mr_valid", {31'b0, exValid},  32'd0);
    checkOutput("mr_scnt",  {16'b0, stallCnt}, 32'd0);
    checkOutput("mr_fcnt",  {16'b0, flushCnt}, 32'd0);
    stepClock();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
